// File: rtl/peach_sprite_fetch.sv
// Purpose: peach sprite hit test, sprite ROM address generation and palette-index alignment.
// Latency: exactly 2 cycles from DrawX/DrawY/pix_valid to index/opaque/out_valid; 1 pixel per cycle.
// Backpressure: none; the stage never stalls, and the sprite ROM must answer within the cycle after rom_addr.
module peach_sprite_fetch #(
  parameter int             SPR_W           = 64,
  parameter int             SPR_H           = 64,
  parameter int             ADDR_W          = 12,
  parameter int             X_W             = 10,
  parameter int             Y_W             = 10,
  parameter logic [7:0]     TRANSPARENT_IDX = 8'd0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [X_W-1:0]    obj_x,
  input  logic [Y_W-1:0]    obj_y,
  input  logic              obj_visible,
  input  logic [X_W-1:0]    DrawX,
  input  logic [Y_W-1:0]    DrawY,
  input  logic              pix_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        index,
  output logic              opaque,
  output logic              out_valid
);

  // Sprite width is a power of two, so the row stride is a plain shift.
  localparam int SHIFT = $clog2(SPR_W);

  // Box extents carried one bit wider than the coordinates so x_l+SPR_W cannot wrap.
  localparam logic [X_W:0] SPR_W_X = (X_W+1)'(SPR_W);
  localparam logic [Y_W:0] SPR_H_Y = (Y_W+1)'(SPR_H);

  // Frame-stable copy of the object position; only these feed the hit test.
  logic [X_W-1:0] x_l;
  logic [Y_W-1:0] y_l;
  logic           vis_l;

  // Stage 0 combinational results.
  logic [X_W:0]     draw_x_ext;
  logic [X_W:0]     box_x_lo;
  logic [X_W:0]     box_x_hi;
  logic [Y_W:0]     draw_y_ext;
  logic [Y_W:0]     box_y_lo;
  logic [Y_W:0]     box_y_hi;
  logic             in_x;
  logic             in_y;
  logic [SHIFT-1:0] dx_lo;
  logic [Y_W-1:0]   dy;
  logic             hit0;
  logic [ADDR_W-1:0] addr0;

  // Stage 1 state travelling alongside rom_addr.
  logic hit1;
  logic v1;

  // Latch the object position only at frame start so the sprite cannot tear mid-frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_l   <= '0;
      y_l   <= '0;
      vis_l <= 1'b0;
    end else if (frame_start) begin
      x_l   <= obj_x;
      y_l   <= obj_y;
      vis_l <= obj_visible;
    end
  end

  // Hit test against the shadow box and row-major address inside the sprite.
  always_comb begin
    draw_x_ext = {1'b0, DrawX};
    box_x_lo   = {1'b0, x_l};
    box_x_hi   = box_x_lo + SPR_W_X;
    draw_y_ext = {1'b0, DrawY};
    box_y_lo   = {1'b0, y_l};
    box_y_hi   = box_y_lo + SPR_H_Y;

    in_x = (draw_x_ext >= box_x_lo) && (draw_x_ext < box_x_hi);
    in_y = (draw_y_ext >= box_y_lo) && (draw_y_ext < box_y_hi);
    hit0 = pix_valid && vis_l && in_x && in_y;

    // Inside the box dx < SPR_W, so only its low SHIFT bits can be non-zero.
    dx_lo = DrawX[SHIFT-1:0] - x_l[SHIFT-1:0];
    dy    = DrawY - y_l;
    addr0 = (ADDR_W'(dy) << SHIFT) | ADDR_W'(dx_lo);
  end

  // Register the ROM address (parked at 0 on misses) and the per-pixel flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      hit1     <= 1'b0;
      v1       <= 1'b0;
    end else begin
      rom_addr <= hit0 ? addr0 : '0;
      hit1     <= hit0;
      v1       <= pix_valid;
    end
  end

  // Capture the ROM answer; misses are forced to the transparent index.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      index     <= '0;
      opaque    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      index     <= hit1 ? rom_data : TRANSPARENT_IDX;
      opaque    <= hit1 && (rom_data != TRANSPARENT_IDX);
      out_valid <= v1;
    end
  end

endmodule

// File: tb/tb_peach_sprite_fetch.sv
module tb_peach_sprite_fetch;

  logic        Clk;
  logic        Reset;
  logic        frame_start;
  logic [9:0]  obj_x;
  logic [9:0]  obj_y;
  logic        obj_visible;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pix_valid;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  index;
  logic        opaque;
  logic        out_valid;

  peach_sprite_fetch dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .obj_x       (obj_x),
    .obj_y       (obj_y),
    .obj_visible (obj_visible),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .pix_valid   (pix_valid),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .index       (index),
    .opaque      (opaque),
    .out_valid   (out_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Sprite ROM contents: 0x2A at address 0, transparent at 5 (and at low byte 0xA5).
  function automatic logic [7:0] rom_fn(input int a);
    logic [31:0] av;
    av = a;
    if (a == 0) return 8'h2A;
    if (a == 5) return 8'h00;
    return av[7:0] ^ 8'hA5;
  endfunction

  // ROM answers the current registered address within the cycle.
  assign rom_data = rom_fn(int'(rom_addr));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Scheduled expectations indexed by absolute cycle number.
  localparam int NC = 1024;
  bit ca [NC];
  bit co [NC];
  int e_addr [NC];
  int e_idx  [NC];
  int e_opq  [NC];
  int e_vld  [NC];

  // Model of the frame-latched object box.
  int m_x = 0, m_y = 0;
  bit m_vis = 0;
  // Object inputs currently presented.
  int g_ox = 0, g_oy = 0;
  bit g_ov = 0;

  // Compare process: checks DUT outputs against the schedule after every edge.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (cyc < NC) begin
        if (ca[cyc]) chk("rom_addr", int'(rom_addr), e_addr[cyc]);
        if (co[cyc]) begin
          chk("index", int'(index), e_idx[cyc]);
          chk("opaque", int'(opaque), e_opq[cyc]);
          chk("out_valid", int'(out_valid), e_vld[cyc]);
        end
      end
    end
  end

  task automatic set_zero_out(input int t);
    co[t] = 1; e_idx[t] = 0; e_opq[t] = 0; e_vld[t] = 0;
  endtask

  // Present one pixel at the falling edge and schedule what it must produce.
  task automatic drive(input bit rst, input bit fs, input int dxp, input int dyp, input bit pv);
    int t, a;
    bit hit;
    logic [7:0] d;
    @(negedge Clk);
    Reset       = rst;
    frame_start = fs;
    obj_x       = 10'(g_ox);
    obj_y       = 10'(g_oy);
    obj_visible = g_ov;
    DrawX       = 10'(dxp);
    DrawY       = 10'(dyp);
    pix_valid   = pv;
    t = cyc;
    if (rst) begin
      m_x = 0; m_y = 0; m_vis = 0;
      ca[t+1] = 1; e_addr[t+1] = 0;
      set_zero_out(t+1);
      set_zero_out(t+2);
    end else begin
      hit = pv && m_vis && dxp >= m_x && dxp < m_x + 64 && dyp >= m_y && dyp < m_y + 64;
      a = hit ? (dyp - m_y) * 64 + (dxp - m_x) : 0;
      d = rom_fn(a);
      ca[t+1] = 1; e_addr[t+1] = a;
      co[t+2] = 1;
      e_idx[t+2] = hit ? int'(d) : 0;
      e_opq[t+2] = (hit && d != 8'h00) ? 1 : 0;
      e_vld[t+2] = pv ? 1 : 0;
      if (fs) begin m_x = g_ox; m_y = g_oy; m_vis = g_ov; end
    end
  endtask

  initial begin
    Reset = 1'b1; frame_start = 0; obj_x = 0; obj_y = 0; obj_visible = 0;
    DrawX = 0; DrawY = 0; pix_valid = 0;

    repeat (3) drive(1, 0, 0, 0, 0);

    // Frame with sprite at (100,50), then reset in the middle of a line.
    g_ox = 100; g_oy = 50; g_ov = 1;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 110, 55, 1);
    drive(0, 0, 120, 60, 1);
    drive(1, 0, 120, 60, 1);
    #1;
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_index", int'(index), 0);
    chk("rst_opaque", int'(opaque), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    drive(1, 0, 120, 60, 1);
    drive(0, 0, 100, 50, 1);
    drive(0, 0, 130, 70, 1);
    chk("post_rst_addr", int'(rom_addr), 0);
    chk("post_rst_flush", int'(out_valid), 0);
    drive(0, 0, 163, 113, 1);
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_opaque", int'(opaque), 0);

    // Box corners and edges.
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 100, 50, 1);
    drive(0, 0, 163, 113, 1);
    chk("corner0_addr", int'(rom_addr), 0);
    drive(0, 0, 164, 113, 1);
    chk("corner1_addr", int'(rom_addr), 4095);
    chk("corner0_index", int'(index), 8'h2A);
    chk("corner0_opaque", int'(opaque), 1);
    chk("corner0_valid", int'(out_valid), 1);
    drive(0, 0, 163, 114, 1);
    chk("right_miss_addr", int'(rom_addr), 0);
    chk("corner1_index", int'(index), 8'h5A);
    drive(0, 0, 99, 50, 1);
    chk("right_miss_opaque", int'(opaque), 0);
    chk("right_miss_valid", int'(out_valid), 1);
    drive(0, 0, 101, 51, 0);
    for (int x = 95; x <= 170; x += 5) drive(0, 0, x, 80, 1);
    drive(0, 0, 137, 52, 1);

    // Box touching the right edge of the coordinate space.
    g_ox = 1000;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1023, 50, 1);
    drive(0, 0, 5, 50, 1);
    chk("edge_addr", int'(rom_addr), 23);
    drive(0, 0, 1000, 113, 1);
    chk("nowrap_addr", int'(rom_addr), 0);
    chk("edge_index", int'(index), 8'hB2);
    drive(0, 0, 1000, 114, 1);
    chk("edge_bottom_addr", int'(rom_addr), 4032);
    chk("nowrap_opaque", int'(opaque), 0);

    // Transparent texel inside the box.
    g_ox = 100;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 105, 50, 1);
    drive(0, 0, 0, 0, 0);
    chk("transp_addr", int'(rom_addr), 5);
    drive(0, 0, 0, 0, 0);
    chk("transp_index", int'(index), 0);
    chk("transp_opaque", int'(opaque), 0);
    chk("transp_valid", int'(out_valid), 1);

    // Invisible frame.
    g_ov = 0;
    drive(0, 1, 0, 0, 0);
    for (int x = 100; x < 164; x += 9) drive(0, 0, x, 60, 1);

    // Object moves mid-frame: old box persists until frame_start.
    g_ov = 1; g_ox = 100;
    drive(0, 1, 0, 0, 0);
    g_ox = 200;
    drive(0, 0, 150, 60, 1);
    drive(0, 0, 100, 60, 1);
    drive(0, 0, 210, 60, 1);
    drive(0, 1, 150, 60, 1);
    drive(0, 0, 151, 60, 1);
    chk("fs_same_cycle_addr", int'(rom_addr), 690);
    drive(0, 0, 200, 60, 1);
    chk("old_box_miss_addr", int'(rom_addr), 0);
    drive(0, 0, 0, 0, 0);
    chk("new_box_addr", int'(rom_addr), 640);

    repeat (4) drive(0, 0, 0, 0, 0);
    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/peach_sprite_fetch.md
Name: peach_sprite_fetch

Overview:
Pixel-fetch stage directly upstream of the peach palette lookup. Takes the VGA scan position and the peach object's screen position, and decides whether the current pixel lies inside the sprite box. On a hit it issues the address to the synchronous sprite index ROM. It delivers the 8-bit palette index plus opaque/valid flags, pipeline-aligned, to the palette stage and the colour mapper.

Parameters:
SPR_W, 64, sprite width in pixels (power of two)
SPR_H, 64, sprite height in pixels
ADDR_W, 12, ROM address width; SPR_W*SPR_H <= 2**ADDR_W
X_W, 10, width of X coordinates
Y_W, 10, width of Y coordinates
TRANSPARENT_IDX, 0, palette index treated as transparent

Ports:
Clk  in  1  system/pixel clock
Reset  in  1  asynchronous, active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blank
obj_x  in  X_W  sprite left edge (unsigned)
obj_y  in  Y_W  sprite top edge (unsigned)
obj_visible  in  1  sprite enabled this frame
DrawX  in  X_W  current scan X
DrawY  in  Y_W  current scan Y
pix_valid  in  1  active-video pixel strobe
rom_addr  out  ADDR_W  registered address to sprite ROM (1-cycle read latency)
rom_data  in  8  ROM read data, valid one cycle after rom_addr
index  out  8  palette index to the palette stage
opaque  out  1  pixel is inside the sprite and not transparent
out_valid  out  1  index/opaque correspond to a pix_valid pixel

Behaviour:
- Reset (async, immediate): all outputs 0; shadow regs x_l, y_l, vis_l = 0; all pipeline valid/hit bits 0.
- Shadow latch: on the Clk edge with frame_start=1, capture x_l<=obj_x, y_l<=obj_y, vis_l<=obj_visible. Hit tests use only the shadow regs, so the sprite never tears mid-frame.
- Stage 0 (comb):
  - dx = DrawX - x_l, dy = DrawY - y_l.
  - Bounds are computed at X_W+1 / Y_W+1 bits so x_l+SPR_W does not wrap.
  - hit0 = pix_valid & vis_l & DrawX>=x_l & DrawX<x_l+SPR_W & DrawY>=y_l & DrawY<y_l+SPR_H.
  - addr0 = dy*SPR_W + dx, truncated to ADDR_W (shift-and-or, since SPR_W is a power of two).
- Stage 1 (reg):
  - rom_addr <= hit0 ? addr0 : 0.
  - hit1 <= hit0; v1 <= pix_valid.
- Stage 2 (reg):
  - index <= hit1 ? rom_data : TRANSPARENT_IDX.
  - opaque <= hit1 & (rom_data != TRANSPARENT_IDX).
  - out_valid <= v1.
- Latency: DrawX/DrawY/pix_valid to index/opaque/out_valid is exactly 2 cycles, throughput 1 pixel/cycle, no stalls. Sync/blank signals must be delayed 2 cycles by the instantiating level.
- Simultaneous frame_start and pix_valid in the same cycle: that pixel's hit uses the old shadow values; new values apply from the next cycle. Pixels already in flight are unaffected.
- Off-box pixels and pix_valid=0: rom_addr=0, opaque=0.
- Reset mid-line: pipeline flushed; first out_valid appears 2 cycles after reset deassertion with pix_valid=1. Shadow regs hold 0/invisible until the next frame_start.

Test Plan:
- Reset asserted mid-frame with pix_valid=1 -> index, opaque, out_valid, rom_addr all 0 immediately; after release, vis_l=0 gives opaque=0 until frame_start.
- frame_start with obj_x=100, obj_y=50, obj_visible=1; then DrawX=100, DrawY=50, pix_valid=1 -> rom_addr=0 at +1; ROM returns 0x2A, so index=0x2A, opaque=1, out_valid=1 at +2.
- DrawX=163, DrawY=113 -> rom_addr=4095. DrawX=164 or DrawY=114 -> rom_addr=0, opaque=0, out_valid=1.
- obj_x=1000, DrawX=1023, DrawY=y_l -> hit with rom_addr=23; obj_x=1000, DrawX=5 -> no hit (no wrap).
- ROM returns TRANSPARENT_IDX=0 inside the box -> opaque=0, index=0. obj_visible=0 latched -> opaque=0 for every pixel of the frame.
- obj_x changes from 100 to 200 without frame_start -> hits stay at 100..163; frame_start in the same cycle as DrawX=150 -> that pixel hits (old box), DrawX=151 misses.
